// File: rtl/gsm_resp_parser.sv
// gsm_resp_parser: line parser for GSM modem replies on the UART receive path.
// Recognises "OK", "ERROR", "+CMGS: <n>" and the "> " SMS prompt, and runs a
// reply timeout that is started by the command sequencer through i_arm.
// Matching is done incrementally as bytes arrive. Only per-pattern match flags,
// the line length and the running decimal value are kept, so the verdict is
// ready on the terminating byte and no separate evaluation cycle is needed.
module gsm_resp_parser #(
    parameter int MAX_LINE    = 16,
    parameter int TIMEOUT_CYC = 90_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_arm,
    output logic       o_ok_pulse,
    output logic       o_err_pulse,
    output logic       o_prompt_pulse,
    output logic       o_cmgs_pulse,
    output logic [7:0] o_cmgs_ref,
    output logic       o_timeout_pulse,
    output logic       o_waiting,
    output logic       o_ovf_pulse
);

    localparam int          LEN_W    = $clog2(MAX_LINE + 1);
    localparam int          CNT_W    = 27;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [7:0]  CH_CR    = 8'h0D;
    localparam logic [7:0]  CH_LF    = 8'h0A;
    localparam logic [7:0]  CH_GT    = 8'h3E;
    localparam logic [7:0]  CH_SP    = 8'h20;

    typedef enum logic [1:0] {LINE_START, COLLECT, DISCARD} state_t;

    // Expected character of "OK" at a given line position.
    function automatic logic [7:0] ok_char(input int idx);
        case (idx)
            0:       return 8'h4F;
            1:       return 8'h4B;
            default: return 8'h00;
        endcase
    endfunction

    // Expected character of "ERROR" at a given line position.
    function automatic logic [7:0] err_char(input int idx);
        case (idx)
            0:       return 8'h45;
            1:       return 8'h52;
            2:       return 8'h52;
            3:       return 8'h4F;
            4:       return 8'h52;
            default: return 8'h00;
        endcase
    endfunction

    // Expected character of the "+CMGS: " prefix at a given line position.
    function automatic logic [7:0] cmgs_char(input int idx);
        case (idx)
            0:       return 8'h2B;
            1:       return 8'h43;
            2:       return 8'h4D;
            3:       return 8'h47;
            4:       return 8'h53;
            5:       return 8'h3A;
            6:       return 8'h20;
            default: return 8'h00;
        endcase
    endfunction

    // value*10 + digit, clamped to the 10-bit accumulator range.
    function automatic logic [9:0] acc_digit(input logic [9:0] acc, input logic [3:0] d);
        logic [13:0] t;
        t = {4'd0, acc} * 14'd10 + {10'd0, d};
        if (t > 14'd1023) return 10'd1023;
        return t[9:0];
    endfunction

    // Clamp the accumulated reference into the 8-bit output range.
    function automatic logic [7:0] sat8(input logic [9:0] acc);
        if (acc > 10'd255) return 8'hFF;
        return acc[7:0];
    endfunction

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic             r_ok_m;
    logic             r_err_m;
    logic             r_cmgs_m;
    logic             r_gt0;
    logic [9:0]       r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_waiting;
    logic             r_ok;
    logic             r_err;
    logic             r_prompt;
    logic             r_cmgs;
    logic [7:0]       r_cmgs_ref;
    logic             r_to;
    logic             r_ovf;

    int               w_idx;
    logic             w_is_digit;
    logic             w_ok_m;
    logic             w_err_m;
    logic             w_cmgs_m;
    logic [9:0]       w_acc;

    // Match flags and running decimal value as they would be after storing the current byte.
    always_comb begin
        w_idx      = int'(r_len);
        w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
        w_ok_m     = ((w_idx == 0) || r_ok_m) && (w_idx < 2) && (i_rx_data == ok_char(w_idx));
        w_err_m    = ((w_idx == 0) || r_err_m) && (w_idx < 5) && (i_rx_data == err_char(w_idx));
        if (w_idx < 7) begin
            w_cmgs_m = ((w_idx == 0) || r_cmgs_m) && (i_rx_data == cmgs_char(w_idx));
            w_acc    = 10'd0;
        end else begin
            w_cmgs_m = r_cmgs_m && (w_idx < 10) && w_is_digit;
            w_acc    = acc_digit((w_idx == 7) ? 10'd0 : r_acc, i_rx_data[3:0]);
        end
    end

    // Line FSM, registered result pulses and the armed reply timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LINE_START;
            r_len      <= '0;
            r_ok_m     <= 1'b0;
            r_err_m    <= 1'b0;
            r_cmgs_m   <= 1'b0;
            r_gt0      <= 1'b0;
            r_acc      <= 10'd0;
            r_cnt      <= '0;
            r_waiting  <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_prompt   <= 1'b0;
            r_cmgs     <= 1'b0;
            r_cmgs_ref <= 8'd0;
            r_to       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
            r_prompt <= 1'b0;
            r_cmgs   <= 1'b0;
            r_to     <= 1'b0;
            r_ovf    <= 1'b0;

            // CR is transparent: neither stored nor allowed to move the FSM.
            if (i_rx_valid && (i_rx_data != CH_CR)) begin
                if (i_rx_data == CH_LF) begin
                    if (r_state == COLLECT) begin
                        if (r_ok_m && (w_idx == 2)) begin
                            r_ok <= 1'b1;
                        end else if (r_err_m && (w_idx == 5)) begin
                            r_err <= 1'b1;
                        end else if (r_cmgs_m && (w_idx >= 8) && (w_idx <= 10)) begin
                            r_cmgs     <= 1'b1;
                            r_cmgs_ref <= sat8(r_acc);
                        end
                    end
                    r_state <= LINE_START;
                    r_len   <= '0;
                end else if (r_state != DISCARD) begin
                    if (w_idx == MAX_LINE) begin
                        r_ovf   <= 1'b1;
                        r_state <= DISCARD;
                    end else if ((w_idx == 1) && r_gt0 && (i_rx_data == CH_SP)) begin
                        // The prompt is never followed by LF, so it closes the line itself.
                        r_prompt <= 1'b1;
                        r_len    <= '0;
                        r_state  <= LINE_START;
                    end else begin
                        r_len    <= r_len + 1'b1;
                        r_ok_m   <= w_ok_m;
                        r_err_m  <= w_err_m;
                        r_cmgs_m <= w_cmgs_m;
                        r_acc    <= w_acc;
                        r_gt0    <= (w_idx == 0) ? (i_rx_data == CH_GT) : r_gt0;
                        r_state  <= COLLECT;
                    end
                end
            end

            // A new arm always wins, even against a reply pulse in the same cycle.
            if (i_arm) begin
                r_cnt     <= CNT_LOAD;
                r_waiting <= 1'b1;
            end else if (r_waiting) begin
                if (r_ok || r_err || r_prompt) begin
                    r_waiting <= 1'b0;
                    r_cnt     <= '0;
                end else if (r_cnt == CNT_W'(1)) begin
                    r_to      <= 1'b1;
                    r_waiting <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign o_ok_pulse      = r_ok;
    assign o_err_pulse     = r_err;
    assign o_prompt_pulse  = r_prompt;
    assign o_cmgs_pulse    = r_cmgs;
    assign o_cmgs_ref      = r_cmgs_ref;
    assign o_timeout_pulse = r_to;
    assign o_waiting       = r_waiting;
    assign o_ovf_pulse     = r_ovf;

endmodule

// File: tb/tb_gsm_resp_parser.sv
// Bench for gsm_resp_parser: table of reply lines plus hand-written sequences
// for overflow, timeout, arm/reply collision and reset. Expected pulses are
// queued when the terminating byte is driven and are matched cycle-exactly
// against the DUT outputs.
module tb_gsm_resp_parser;

    localparam int MAX_LINE = 16;
    localparam int TO_CYC   = 100;

    localparam int K_OK     = 0;
    localparam int K_ERR    = 1;
    localparam int K_PROMPT = 2;
    localparam int K_CMGS   = 3;
    localparam int K_OVF    = 4;
    localparam int K_TO     = 5;
    localparam int K_NONE   = 6;

    localparam int T_CRLF   = 0;
    localparam int T_NONE   = 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] ref_v;
    } sb_t;

    typedef struct {
        string s;
        int    term;
        int    kind;
        int    rv;
        int    gap;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       arm = 1'b0;
    logic       o_ok_pulse;
    logic       o_err_pulse;
    logic       o_prompt_pulse;
    logic       o_cmgs_pulse;
    logic [7:0] o_cmgs_ref;
    logic       o_timeout_pulse;
    logic       o_waiting;
    logic       o_ovf_pulse;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    sb_t  sb[$];
    vec_t vecs[$];

    gsm_resp_parser #(
        .MAX_LINE   (MAX_LINE),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .i_arm          (arm),
        .o_ok_pulse     (o_ok_pulse),
        .o_err_pulse    (o_err_pulse),
        .o_prompt_pulse (o_prompt_pulse),
        .o_cmgs_pulse   (o_cmgs_pulse),
        .o_cmgs_ref     (o_cmgs_ref),
        .o_timeout_pulse(o_timeout_pulse),
        .o_waiting      (o_waiting),
        .o_ovf_pulse    (o_ovf_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input int at, input logic [7:0] rv);
        sb_t e;
        e.kind  = kind;
        e.cyc   = at;
        e.ref_v = rv;
        sb.push_back(e);
    endtask

    // Called at posedge+1; the byte is sampled on the next edge, its pulse is seen one cycle later.
    task automatic send_byte(input logic [7:0] b, input int kind, input logic [7:0] rv);
        rx_data  = b;
        rx_valid = 1'b1;
        if (kind != K_NONE) push_exp(kind, cyc + 1, rv);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_arm(input int exp_to);
        arm = 1'b1;
        if (exp_to != 0) push_exp(K_TO, cyc + 1 + TO_CYC, 8'd0);
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic send_line(input string s, input int term, input int kind, input int rv, input int gap);
        int n;
        n = s.len();
        for (int i = 0; i < n; i++) begin
            send_byte(s[i], (term == T_NONE && i == n - 1) ? kind : K_NONE, 8'(rv));
            idle(gap);
        end
        if (term == T_CRLF) begin
            send_byte(8'h0D, K_NONE, 8'd0);
            send_byte(8'h0A, kind, 8'(rv));
        end
    endtask

    task automatic add_vec(input string s, input int term, input int kind, input int rv, input int gap);
        vec_t v;
        v.s    = s;
        v.term = term;
        v.kind = kind;
        v.rv   = rv;
        v.gap  = gap;
        vecs.push_back(v);
    endtask

    task automatic monitor_loop();
        sb_t        e;
        logic [5:0] pv;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_pulse kind=%0d actual=absent required=cycle %0d (now %0d)", e.kind, e.cyc, cyc);
            end
            pv = {o_timeout_pulse, o_ovf_pulse, o_cmgs_pulse, o_prompt_pulse, o_err_pulse, o_ok_pulse};
            if (pv != 6'd0) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=%b required=none (cycle %0d)", pv, cyc);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", 32'(pv), 32'(1 << e.kind));
                    if (e.kind == K_CMGS) check("cmgs_ref", 32'(o_cmgs_ref), 32'(e.ref_v));
                end
            end
        end
    endtask

    initial begin
        add_vec("ERROR",            T_CRLF, K_ERR,    0, 0);
        add_vec("ERRORX",           T_CRLF, K_NONE,   0, 0);
        add_vec("ERROR",            T_CRLF, K_ERR,    0, 2);
        add_vec("ok",               T_CRLF, K_NONE,   0, 0);
        add_vec("OKK",              T_CRLF, K_NONE,   0, 0);
        add_vec("O\015K",           T_CRLF, K_OK,     0, 1);
        add_vec("+CMGS: 42",        T_CRLF, K_CMGS,  42, 0);
        add_vec("+CMGS: 999",       T_CRLF, K_CMGS, 255, 0);
        add_vec("+CMGS: 0",         T_CRLF, K_CMGS,   0, 0);
        add_vec("+CMGS: 256",       T_CRLF, K_CMGS, 255, 0);
        add_vec("+CMGS: 7",         T_CRLF, K_CMGS,   7, 1);
        add_vec("+CMGS: ",          T_CRLF, K_NONE,   0, 0);
        add_vec("+CMGS: 4a",        T_CRLF, K_NONE,   0, 0);
        add_vec("+CMGS: 1234",      T_CRLF, K_NONE,   0, 0);
        add_vec("+CMGS:42",         T_CRLF, K_NONE,   0, 0);
        add_vec("+CSCS: GSM",       T_CRLF, K_NONE,   0, 0);
        add_vec("AAAAAAAAAAAAAAAA", T_CRLF, K_NONE,   0, 0);
        add_vec("> ",               T_NONE, K_PROMPT, 0, 0);
        add_vec("A> ",              T_CRLF, K_NONE,   0, 0);
        add_vec(">x",               T_CRLF, K_NONE,   0, 0);
        add_vec("OK",               T_CRLF, K_OK,     0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({o_ok_pulse, o_err_pulse, o_prompt_pulse, o_cmgs_pulse, o_cmgs_ref,
                   o_timeout_pulse, o_waiting, o_ovf_pulse}), 32'd0);
        rst = 1'b1;
        idle(2);
        fork
            monitor_loop();
        join_none

        // Echo and blank line ignored, OK ends the armed wait
        pulse_arm(0);
        check("waiting_after_arm", 32'(o_waiting), 32'd1);
        send_line("AT", T_CRLF, K_NONE, 0, 0);
        send_line("",   T_CRLF, K_NONE, 0, 0);
        send_line("OK", T_CRLF, K_OK,   0, 0);
        idle(3);
        check("waiting_after_ok", 32'(o_waiting), 32'd0);

        // Table of reply lines
        for (int i = 0; i < vecs.size(); i++) begin
            send_line(vecs[i].s, vecs[i].term, vecs[i].kind, vecs[i].rv, vecs[i].gap);
        end
        idle(2);
        check("cmgs_ref_held", 32'(o_cmgs_ref), 32'd7);

        // Prompt clears waiting; +CMGS does not
        pulse_arm(0);
        send_line("> ", T_NONE, K_PROMPT, 0, 0);
        idle(2);
        check("waiting_after_prompt", 32'(o_waiting), 32'd0);
        pulse_arm(0);
        send_line("+CMGS: 42", T_CRLF, K_CMGS, 42, 0);
        idle(2);
        check("waiting_after_cmgs", 32'(o_waiting), 32'd1);
        send_line("ERROR", T_CRLF, K_ERR, 0, 0);
        idle(2);
        check("waiting_after_err", 32'(o_waiting), 32'd0);

        // Overlong line: overflow on the 17th byte, rest dropped, next line still parsed
        for (int i = 0; i < 20; i++) begin
            send_byte(8'h41, (i == MAX_LINE) ? K_OVF : K_NONE, 8'd0);
        end
        send_byte(8'h0D, K_NONE, 8'd0);
        send_byte(8'h0A, K_NONE, 8'd0);
        send_line("OK", T_CRLF, K_OK, 0, 0);
        idle(2);

        // Plain timeout
        pulse_arm(1);
        idle(TO_CYC - 5);
        check("waiting_before_timeout", 32'(o_waiting), 32'd1);
        idle(10);
        check("waiting_after_timeout", 32'(o_waiting), 32'd0);

        // Re-arm halfway restarts the count
        pulse_arm(0);
        idle(49);
        pulse_arm(1);
        idle(TO_CYC + 5);
        check("waiting_after_rearm_timeout", 32'(o_waiting), 32'd0);

        // Arm in the same cycle as the OK pulse keeps waiting
        send_line("OK", T_CRLF, K_OK, 0, 0);
        pulse_arm(1);
        idle(3);
        check("waiting_arm_vs_ok", 32'(o_waiting), 32'd1);
        idle(TO_CYC + 2);
        check("waiting_after_collision_timeout", 32'(o_waiting), 32'd0);

        // Reset mid-line and mid-wait
        pulse_arm(0);
        send_line("+CM", T_NONE, K_NONE, 0, 0);
        rst = 1'b0;
        idle(2);
        check("outputs_in_reset",
              32'({o_ok_pulse, o_err_pulse, o_prompt_pulse, o_cmgs_pulse, o_cmgs_ref,
                   o_timeout_pulse, o_waiting, o_ovf_pulse}), 32'd0);
        rst = 1'b1;
        idle(1);
        send_line("OK", T_CRLF, K_OK, 0, 0);
        idle(3);
        check("waiting_after_reset", 32'(o_waiting), 32'd0);

        idle(TO_CYC + 5);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
